// File: rtl/multicycle_control_if.sv
// Control-unit boundary: instruction/flag inputs from the datapath, enables back to it.
interface multicycle_control_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned CNTW = 16
);
  logic [OPW-1:0]  OpCode;
  logic            Zero;
  logic            MemReady;
  logic            PCWrite;
  logic            PCSrc;
  logic            EnIM;
  logic            IRWrite;
  logic            ALUSrcB;
  logic [2:0]      ALUOp;
  logic            MR;
  logic            MW;
  logic            MReg;
  logic            EnRW;
  logic [2:0]      State;
  logic            IllegalOp;
  logic            MemTimeout;
  logic [CNTW-1:0] RetCount;

  // Controller side
  modport master (
    input  OpCode, Zero, MemReady,
    output PCWrite, PCSrc, EnIM, IRWrite, ALUSrcB, ALUOp, MR, MW, MReg, EnRW,
    output State, IllegalOp, MemTimeout, RetCount
  );

  // Datapath / instruction-register side
  modport slave (
    output OpCode, Zero, MemReady,
    input  PCWrite, PCSrc, EnIM, IRWrite, ALUSrcB, ALUOp, MR, MW, MReg, EnRW,
    input  State, IllegalOp, MemTimeout, RetCount
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory-ready timeout, illegal-opcode trap and retired-instruction counter.
module multicycle_control #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNTW    = 16
) (
  input logic                 Clk,
  input logic                 Rst,
  multicycle_control_if.master bus
);

  localparam int unsigned WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORI  = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      op_reg;
  logic [WCW-1:0]  wait_cnt;
  logic            illegal_op;
  logic            mem_timeout;
  logic [CNTW-1:0] ret_count;

  logic [OPW-1:0]  op_in;
  logic [31:0]     op_ext;
  logic            op_legal;
  logic            timeout_hit;
  logic            retire;

  assign op_in  = bus.OpCode;
  assign op_ext = 32'(op_in);

  // Legal opcode: upper bits clear and low nibble in the decode table
  always_comb begin
    op_legal = 1'b0;
    if (op_ext[31:4] == 28'd0) begin
      case (op_ext[3:0])
        OP_AND, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_NAND, OP_ADD: op_legal = 1'b1;
        default:                                               op_legal = 1'b0;
      endcase
    end
  end

  // This MEM cycle without ready is the TIMEOUT-th one
  assign timeout_hit = (TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) == TIMEOUT);

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = op_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op_reg)
          OP_BEQ:       state_nx = S_FETCH;
          OP_LW, OP_SW: state_nx = S_MEM;
          default:      state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.MemReady)     state_nx = (op_reg == OP_LW) ? S_WB : S_FETCH;
        else if (timeout_hit) state_nx = S_TRAP;
      end
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign retire = (state_nx == S_FETCH) &&
                  ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

  // Moore control decode from state and latched opcode (BEQ PCWrite follows Zero)
  always_comb begin
    bus.PCWrite = 1'b0;
    bus.PCSrc   = 1'b0;
    bus.EnIM    = 1'b0;
    bus.IRWrite = 1'b0;
    bus.ALUSrcB = 1'b0;
    bus.ALUOp   = 3'b000;
    bus.MR      = 1'b0;
    bus.MW      = 1'b0;
    bus.MReg    = 1'b0;
    bus.EnRW    = 1'b0;
    case (state)
      S_FETCH: begin
        bus.PCWrite = 1'b1;
        bus.EnIM    = 1'b1;
        bus.IRWrite = 1'b1;
      end
      S_EXEC: begin
        case (op_reg)
          OP_AND:  begin bus.ALUSrcB = 1'b1; bus.ALUOp = 3'b000; end
          OP_ORI:  begin bus.ALUSrcB = 1'b0; bus.ALUOp = 3'b001; end
          OP_LW,
          OP_SW:   begin bus.ALUSrcB = 1'b0; bus.ALUOp = 3'b010; end
          OP_BEQ: begin
            bus.ALUSrcB = 1'b1;
            bus.ALUOp   = 3'b100;
            bus.PCSrc   = 1'b1;
            bus.PCWrite = bus.Zero;
          end
          OP_NAND: begin bus.ALUSrcB = 1'b1; bus.ALUOp = 3'b011; end
          OP_ADD:  begin bus.ALUSrcB = 1'b1; bus.ALUOp = 3'b010; end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.MR = (op_reg == OP_LW);
        bus.MW = (op_reg == OP_SW);
      end
      S_WB: begin
        bus.EnRW = 1'b1;
        bus.MReg = (op_reg == OP_LW);
      end
      default: ;
    endcase
  end

  // Opcode latch, MEM wait counter, sticky flags and retire counter
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_reg      <= 4'd0;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
      ret_count   <= '0;
    end else begin
      if (state == S_DECODE) op_reg <= op_ext[3:0];
      if ((state == S_MEM) && (state_nx == S_MEM)) wait_cnt <= wait_cnt + WCW'(1);
      else                                         wait_cnt <= '0;
      if ((state == S_DECODE) && !op_legal)          illegal_op  <= 1'b1;
      if ((state == S_MEM) && (state_nx == S_TRAP))  mem_timeout <= 1'b1;
      if (retire) ret_count <= ret_count + CNTW'(1);
    end
  end

  assign bus.State      = state;
  assign bus.IllegalOp  = illegal_op;
  assign bus.MemTimeout = mem_timeout;
  assign bus.RetCount   = ret_count;

endmodule
